arm_run_controller: RTL and testbench
=====================================

// Module: arm_run_controller
// PURPOSE
//  Synthesizable run sequencer for the ARM pipeline core, replacing hand-timed bench reset/mode stimulus.
//  Executes NUM_RUNS back-to-back runs of the program already loaded in the core.
//  Each run applies a RST_CYCLES core reset with a per-run forward_en mode, then counts cycles to core halt or MAX_CYCLES.
//  Reports one result per run. Sits between the bench or top-level and the ARM core's rst/forward_en inputs.
// PARAMETERS
//  CNT_W       16    cycle-counter / result width
//  RST_CYCLES  4     core reset length in clk cycles, >=1
//  MAX_CYCLES  1000  per-run timeout, < 2**CNT_W
//  NUM_RUNS    2     runs per start; run i uses mode_mask[i]
// PORTS
//  clk            in   1         clock, rising edge
//  rst            in   1         asynchronous, active-low controller reset
//  start          in   1         1-cycle pulse; accepted only in IDLE
//  mode_mask      in   NUM_RUNS  forward_en value per run, sampled at start
//  core_halt      in   1         level from core: program finished
//  core_rst       out  1         active-high reset to ARM core
//  forward_en     out  1         forwarding enable to ARM core
//  busy           out  1         high from accepted start until all_done
//  run_idx        out  RW        current run, RW=$clog2(NUM_RUNS) (min 1)
//  result_valid   out  1         1-cycle pulse per finished run
//  result_cycles  out  CNT_W     RUN-state cycles of that run
//  result_timeout out  1         run ended by MAX_CYCLES, not halt
//  all_done       out  1         1-cycle pulse after last result
// BEHAVIOUR
//  rst low: FSM=IDLE; core_rst=1; forward_en=0; busy=0; run_idx=0.
//  rst low: result_valid=0; result_cycles=0; result_timeout=0; all_done=0. Core is held in reset while idle.
//  States: IDLE -> CRST -> RUN -> REPORT -> (CRST | FIN) -> IDLE.
//  IDLE: start=1 latches mode_mask into mask_q and clears run_idx. Next state CRST.
//  CRST: core_rst=1, forward_en=mask_q[run_idx]; hold exactly RST_CYCLES cycles; then RUN.
//  forward_en changes only on the CRST entry edge and is stable for the whole run.
//  RUN: core_rst=0; cnt increments every cycle starting at 1 in the first RUN cycle.
//  RUN exit on core_halt=1: result_cycles=cnt value in that cycle, timeout=0.
//  RUN exit when cnt==MAX_CYCLES with no halt: result_cycles=MAX_CYCLES, timeout=1.
//  Halt and limit in the same cycle: halt wins, timeout=0.
//  core_halt is ignored outside RUN; a halt during CRST does not end the run.
//  REPORT: core_rst=1; result_valid=1 for one cycle; result_* held until the next REPORT.
//  REPORT next state: CRST with run_idx+1 if run_idx<NUM_RUNS-1, else FIN.
//  FIN: all_done=1 for one cycle; busy drops on the same edge; core_rst stays 1; -> IDLE.
//  start pulses while busy are ignored, not queued.
//  rst asserted mid-run: immediate return to reset values; no result or all_done for the aborted run.
//  Counter never wraps: MAX_CYCLES < 2**CNT_W is checked at elaboration (generate-time error).
// CONFIGURATION
//  Macro ARM_RUN_CTRL_STALL_CNT_EN.
//  Defined: adds in core_stall[1] and out result_stalls[CNT_W].
//  Defined: result_stalls counts RUN cycles with core_stall=1 and is updated in REPORT alongside result_cycles.
//  Defined: result_stalls resets to 0.
//  Undefined: neither port exists; all other behaviour is identical.
// STRUCTURE
//  Package arm_run_pkg: state enum {IDLE,CRST,RUN,REPORT,FIN}; CNT_W default.
//  arm_run_pkg also holds the localparam helper for run_idx width.
//  Sub-module arm_sat_counter (CNT_W, clear, enable, count, at_limit).
//  Instanced once for the run counter and the reset-length counter; under the macro, once more for stalls.
// TESTING
//  Reset: rst=0 at t=10ns -> core_rst=1, busy=0, all outputs at reset values; hold 5 cycles, unchanged.
//  Two runs: mask=2'b10, halt 37 cycles into run 0 and 22 into run 1.
//    -> forward_en 0 then 1; results 37/0 and 22/0; all_done one cycle after second result_valid.
//  Timeout: MAX_CYCLES=50, halt never asserted -> result_cycles=50, timeout=1, core_rst=1 in REPORT.
//  Halt on the same cycle cnt==MAX_CYCLES -> timeout=0, cycles=MAX_CYCLES.
//  Reset length: core_rst high for exactly RST_CYCLES=4 cycles before each RUN; start during busy is ignored.
//  Abort: rst=0 mid-RUN of run 1 -> no result_valid/all_done; after release, a new start runs from run_idx=0.
//  Macro on: core_stall high for 9 of 30 run cycles -> result_stalls=9.

Source files
------------

// File: rtl/arm_run_pkg.sv
// Shared types for the ARM run sequencer: sequencer states, default counter width,
// and the run-index width helper (never narrower than one bit).
package arm_run_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CRST   = 3'd1,
        RUN    = 3'd2,
        REPORT = 3'd3,
        FIN    = 3'd4
    } state_e;

    function automatic int run_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arm_sat_counter.sv
// Purpose: saturating up-counter with synchronous clear, stops at LIMIT.
// Latency: count visible the cycle after an enabled edge; at_limit is combinational.
// Backpressure: none, enable is a plain qualifier.
module arm_sat_counter #(
    parameter int               CNT_W = 16,
    parameter logic [CNT_W-1:0] LIMIT = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [CNT_W-1:0] o_count,
    output logic             o_at_limit
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_at_limit) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count    = r_count;
    assign o_at_limit = (r_count == LIMIT);

endmodule

// File: rtl/arm_run_controller.sv
// Purpose: sequences NUM_RUNS reset+run passes of the ARM core, one result per run.
// Latency: RST_CYCLES core reset, then up to MAX_CYCLES run, result one cycle after exit.
// Backpressure: none; start is ignored while busy. Macro ARM_RUN_CTRL_STALL_CNT_EN adds stall counting.
module arm_run_controller
    import arm_run_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int RST_CYCLES = 4,
    parameter int MAX_CYCLES = 1000,
    parameter int NUM_RUNS   = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [NUM_RUNS-1:0]               mode_mask,
    input  logic                              core_halt,
`ifdef ARM_RUN_CTRL_STALL_CNT_EN
    input  logic                              core_stall,
    output logic [CNT_W-1:0]                  result_stalls,
`endif
    output logic                              core_rst,
    output logic                              forward_en,
    output logic                              busy,
    output logic [run_idx_w(NUM_RUNS)-1:0]    run_idx,
    output logic                              result_valid,
    output logic [CNT_W-1:0]                  result_cycles,
    output logic                              result_timeout,
    output logic                              all_done
);

    localparam int RW = run_idx_w(NUM_RUNS);

    generate
        if (MAX_CYCLES < 1 || (MAX_CYCLES >> CNT_W) != 0) begin : g_bad_max_cycles
            $error("arm_run_controller: MAX_CYCLES must be in 1 .. 2**CNT_W-1");
        end
        if (RST_CYCLES < 1 || (RST_CYCLES >> CNT_W) != 0) begin : g_bad_rst_cycles
            $error("arm_run_controller: RST_CYCLES must be in 1 .. 2**CNT_W-1");
        end
    endgenerate

    state_e            r_state;
    state_e            w_next;
    logic [NUM_RUNS-1:0] r_mask;
    logic [RW-1:0]     r_run_idx;
    logic [RW-1:0]     w_idx_nxt;
    logic              r_fwd;
    logic [CNT_W-1:0]  r_res_cycles;
    logic              r_res_timeout;
    logic [CNT_W-1:0]  w_run_cnt;
    logic              w_run_lim;
    logic [CNT_W-1:0]  w_rst_cnt_unused;
    logic              w_rst_done;
    logic              w_last_run;
    logic              w_run_exit;

    // Run counter holds cycles-so-far minus one, so the live count is w_run_cnt+1.
    arm_sat_counter #(.CNT_W(CNT_W), .LIMIT(CNT_W'(MAX_CYCLES - 1))) u_run_cnt (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (r_state != RUN),
        .i_enable  (r_state == RUN),
        .o_count   (w_run_cnt),
        .o_at_limit(w_run_lim)
    );

    arm_sat_counter #(.CNT_W(CNT_W), .LIMIT(CNT_W'(RST_CYCLES - 1))) u_rst_cnt (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (r_state != CRST),
        .i_enable  (r_state == CRST),
        .o_count   (w_rst_cnt_unused),
        .o_at_limit(w_rst_done)
    );

    assign w_last_run = (r_run_idx == RW'(NUM_RUNS - 1));
    assign w_idx_nxt  = r_run_idx + RW'(1);
    assign w_run_exit = core_halt || w_run_lim;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = CRST;
            CRST:    if (w_rst_done) w_next = RUN;
            RUN:     if (w_run_exit) w_next = REPORT;
            REPORT:  w_next = w_last_run ? FIN : CRST;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_mask        <= '0;
            r_run_idx     <= '0;
            r_fwd         <= 1'b0;
            r_res_cycles  <= '0;
            r_res_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start) begin
                r_mask    <= mode_mask;
                r_run_idx <= '0;
                r_fwd     <= mode_mask[0];
            end
            if (r_state == REPORT && !w_last_run) begin
                r_run_idx <= w_idx_nxt;
                r_fwd     <= r_mask[w_idx_nxt];
            end
            // Halt wins a tie with the limit; the count equals MAX_CYCLES either way.
            if (r_state == RUN && w_run_exit) begin
                r_res_cycles  <= w_run_cnt + CNT_W'(1);
                r_res_timeout <= !core_halt;
            end
        end
    end

`ifdef ARM_RUN_CTRL_STALL_CNT_EN
    logic [CNT_W-1:0] w_stall_cnt;
    logic             w_stall_lim;
    logic [CNT_W-1:0] r_res_stalls;

    arm_sat_counter #(.CNT_W(CNT_W), .LIMIT('1)) u_stall_cnt (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (r_state != RUN),
        .i_enable  ((r_state == RUN) && core_stall),
        .o_count   (w_stall_cnt),
        .o_at_limit(w_stall_lim)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_res_stalls <= '0;
        end else if (r_state == RUN && w_run_exit) begin
            r_res_stalls <= w_stall_cnt + CNT_W'(core_stall & ~w_stall_lim);
        end
    end

    assign result_stalls = r_res_stalls;
`endif

    assign core_rst       = (r_state != RUN);
    assign forward_en     = r_fwd;
    assign busy           = (r_state != IDLE);
    assign run_idx        = r_run_idx;
    assign result_valid   = (r_state == REPORT);
    assign result_cycles  = r_res_cycles;
    assign result_timeout = r_res_timeout;
    assign all_done       = (r_state == FIN);

endmodule

// File: tb/tb_arm_run_controller.sv
// Bench for arm_run_controller: behavioural core model plus a scoreboard of expected per-run results.
module tb_arm_run_controller;

    localparam int CNT_W   = 16;
    localparam int RST_C   = 4;
    localparam int MAXC    = 50;
    localparam int NR      = 2;
    localparam int STALL_N = 9;

    typedef struct {
        logic fwd;
        int   idx;
        int   cycles;
        logic tmo;
        int   stalls;
    } sb_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [NR-1:0]    mode_mask;
    logic             core_halt;
    logic             core_rst;
    logic             forward_en;
    logic             busy;
    logic [0:0]       run_idx;
    logic             result_valid;
    logic [CNT_W-1:0] result_cycles;
    logic             result_timeout;
    logic             all_done;
`ifdef ARM_RUN_CTRL_STALL_CNT_EN
    logic             core_stall;
    logic [CNT_W-1:0] result_stalls;
`endif

    sb_t  fall_q[$];
    sb_t  rep_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   hi_cnt = 0;
    int   last_rv = 0;
    int   last_exp_cycles = 0;
    int   n_results = 0;
    int   n_done = 0;
    int   exp_done = 0;
    int   core_cyc = 0;
    int   halt_tgt[NR];
    logic xhalt = 1'b0;
    logic mon_en = 1'b0;
    logic prev_crst = 1'b1;

    arm_run_controller #(
        .CNT_W(CNT_W), .RST_CYCLES(RST_C), .MAX_CYCLES(MAXC), .NUM_RUNS(NR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .mode_mask     (mode_mask),
        .core_halt     (core_halt),
`ifdef ARM_RUN_CTRL_STALL_CNT_EN
        .core_stall    (core_stall),
        .result_stalls (result_stalls),
`endif
        .core_rst      (core_rst),
        .forward_en    (forward_en),
        .busy          (busy),
        .run_idx       (run_idx),
        .result_valid  (result_valid),
        .result_cycles (result_cycles),
        .result_timeout(result_timeout),
        .all_done      (all_done)
    );

    always #5 clk = ~clk;

    // Core model: counts cycles out of reset, halts on its per-run target cycle (0 = never).
    always @(posedge clk) core_cyc <= core_rst ? 0 : core_cyc + 1;
    assign core_halt = xhalt | (!core_rst && halt_tgt[run_idx] != 0 && core_cyc + 1 == halt_tgt[run_idx]);
`ifdef ARM_RUN_CTRL_STALL_CNT_EN
    assign core_stall = !core_rst && core_cyc < STALL_N;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_reset();
        check("rst_core_rst", core_rst, 1);
        check("rst_forward_en", forward_en, 0);
        check("rst_busy", busy, 0);
        check("rst_run_idx", run_idx, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_result_cycles", result_cycles, 0);
        check("rst_result_timeout", result_timeout, 0);
        check("rst_all_done", all_done, 0);
`ifdef ARM_RUN_CTRL_STALL_CNT_EN
        check("rst_result_stalls", result_stalls, 0);
`endif
    endtask

    task automatic push_run(input logic fwd, input int idx, input int tgt);
        sb_t e;
        e.fwd = fwd;
        e.idx = idx;
        if (tgt != 0 && tgt <= MAXC) begin
            e.cycles = tgt;
            e.tmo    = 1'b0;
        end else begin
            e.cycles = MAXC;
            e.tmo    = 1'b1;
        end
        e.stalls = (e.cycles < STALL_N) ? e.cycles : STALL_N;
        fall_q.push_back(e);
        rep_q.push_back(e);
    endtask

    task automatic run_seq(input logic [NR-1:0] mask, input int t0, input int t1, input bit full);
        halt_tgt[0] = t0;
        halt_tgt[1] = t1;
        push_run(mask[0], 0, t0);
        push_run(mask[1], 1, t1);
        if (full) exp_done++;
        @(negedge clk);
        mode_mask = mask;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done();
        int d0 = n_done;
        for (int i = 0; i < 1000 && n_done == d0; i++) @(posedge clk);
        check("done_seen", n_done != d0, 1);
    endtask

    // Output monitor: checks reset length, run setup, each result and the completion pulse.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (mon_en && rst) begin
            prev_crst <= core_rst;
            hi_cnt    <= (busy && core_rst && !result_valid && !all_done) ? hi_cnt + 1 : 0;
            if (!core_rst && prev_crst) begin
                check("crst_len", hi_cnt, RST_C);
                if (fall_q.size() == 0) begin
                    check("unexpected_run", 1, 0);
                end else begin
                    check("run_fwd", forward_en, fall_q[0].fwd);
                    check("run_idx", run_idx, fall_q[0].idx);
                    fall_q.delete(0);
                end
            end
            if (result_valid) begin
                check("rpt_core_rst", core_rst, 1);
                last_rv   <= cyc;
                n_results <= n_results + 1;
                if (rep_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    check("res_cycles", result_cycles, rep_q[0].cycles);
                    check("res_timeout", result_timeout, rep_q[0].tmo);
                    check("rpt_fwd_stable", forward_en, rep_q[0].fwd);
`ifdef ARM_RUN_CTRL_STALL_CNT_EN
                    check("res_stalls", result_stalls, rep_q[0].stalls);
`endif
                    last_exp_cycles <= rep_q[0].cycles;
                    rep_q.delete(0);
                end
            end
            if (all_done) begin
                n_done <= n_done + 1;
                check("done_gap", cyc - last_rv, 1);
                check("done_busy", busy, 1);
                check("done_core_rst", core_rst, 1);
                check("done_res_held", result_cycles, last_exp_cycles);
                check("done_pending", rep_q.size(), 0);
            end
        end else begin
            hi_cnt    <= 0;
            prev_crst <= 1'b1;
        end
    end

    initial begin
        int nr0;
        int nd0;
        rst         = 1'b1;
        start       = 1'b0;
        mode_mask   = '0;
        halt_tgt[0] = 0;
        halt_tgt[1] = 0;

        #10 rst = 1'b0;
        #1 chk_reset();
        repeat (5) @(posedge clk);
        #1 chk_reset();
        @(negedge clk);
        rst    = 1'b1;
        mon_en = 1'b1;

        // Two runs; halt during CRST must be ignored, a start while busy must be ignored.
        run_seq(2'b10, 37, 22, 1'b1);
        xhalt = 1'b1;
        repeat (2) @(negedge clk);
        xhalt = 1'b0;
        repeat (10) @(negedge clk);
        mode_mask = 2'b01;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_core_rst", core_rst, 1);

        // Run 0 times out, run 1 halts exactly at the limit.
        run_seq(2'b01, 0, MAXC, 1'b1);
        wait_done();
        repeat (3) @(negedge clk);

        // Abort in the middle of run 1.
        run_seq(2'b10, 37, 0, 1'b0);
        for (int i = 0; i < 500 && !(run_idx == 1'b1 && !core_rst); i++) @(negedge clk);
        check("abort_reach_run1", (run_idx == 1'b1 && !core_rst), 1);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1 chk_reset();
        nr0 = n_results;
        nd0 = n_done;
        fall_q.delete();
        rep_q.delete();
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_no_result", n_results, nr0);
        check("abort_no_done", n_done, nd0);
        check("abort_idle", busy, 0);

        // Fresh start after abort begins again at run 0.
        run_seq(2'b11, 30, 3, 1'b1);
        wait_done();
        repeat (3) @(negedge clk);

        check("done_count", n_done, exp_done);
        check("sb_empty", rep_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
